// File: rtl/pe_bypass_ctrl_pkg.sv
// Shared encodings and record types for the PE bypass controller.
// The EX record tracks the single producer one stage ahead of IF.
package pe_bypass_ctrl_pkg;

  localparam int DEF_RF_INDEX_WIDTH = 5;
  localparam int DEF_SHADOW_IDX     = 31;

  typedef enum logic [1:0] {
    BYPASS_SRC_ALU    = 2'd0,
    BYPASS_SRC_MUL    = 2'd1,
    BYPASS_SRC_LSU    = 2'd2,
    BYPASS_SRC_SHADOW = 2'd3
  } bypass_src_e;

  // rem is one bit wide because unit latency never exceeds 2.
  typedef struct packed {
    logic                          vld;
    logic [DEF_RF_INDEX_WIDTH-1:0] dst;
    bypass_src_e                   src;
    logic                          rem;
  } ex_rec_t;

  typedef struct packed {
    logic        rd_a;
    logic        rd_b;
    bypass_src_e sel_a;
    bypass_src_e sel_b;
  } bp_out_t;

  function automatic logic rem_init(input bypass_src_e src, input int mul_lat, input int lsu_lat);
    case (src)
      BYPASS_SRC_MUL: return (mul_lat > 1);
      BYPASS_SRC_LSU: return (lsu_lat > 1);
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pe_bypass_ctrl_if.sv
// IF-side request and ID-side bypass control bundle.
// master drives the IF instruction fields; slave is the bypass controller.
interface pe_bypass_ctrl_if #(
  parameter int RF_IDX_W = 5
);
  logic                iPipe_Stall;
  logic                iIF_Valid;
  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_A;
  logic [RF_IDX_W-1:0] iIF_RF_Read_Addr_B;
  logic                iIF_Read_En_A;
  logic                iIF_Read_En_B;
  logic                iIF_Dest_Write;
  logic [RF_IDX_W-1:0] iIF_Dest_Addr;
  logic [1:0]          iIF_Dest_Src;
  logic                oBP_Bypass_Read_A;
  logic                oBP_Bypass_Read_B;
  logic [1:0]          oBP_Bypass_Sel_A;
  logic [1:0]          oBP_Bypass_Sel_B;
  logic                oHazard_Stall;

  modport master (
    output iPipe_Stall, iIF_Valid, iIF_RF_Read_Addr_A, iIF_RF_Read_Addr_B,
           iIF_Read_En_A, iIF_Read_En_B, iIF_Dest_Write, iIF_Dest_Addr, iIF_Dest_Src,
    input  oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B,
           oHazard_Stall
  );

  modport slave (
    input  iPipe_Stall, iIF_Valid, iIF_RF_Read_Addr_A, iIF_RF_Read_Addr_B,
           iIF_Read_En_A, iIF_Read_En_B, iIF_Dest_Write, iIF_Dest_Addr, iIF_Dest_Src,
    output oBP_Bypass_Read_A, oBP_Bypass_Read_B, oBP_Bypass_Sel_A, oBP_Bypass_Sel_B,
           oHazard_Stall
  );
endinterface

// File: rtl/pe_bypass_ctrl.sv
// Bypass flag/select generator: flags land one cycle after IF issue; hazard is combinational.
// iPipe_Stall freezes record and outputs; a MUL/LSU dependency costs one bubble cycle.
module pe_bypass_ctrl
  import pe_bypass_ctrl_pkg::*;
#(
  parameter int RF_IDX_W    = DEF_RF_INDEX_WIDTH,
  parameter int MUL_LATENCY = 2,
  parameter int LSU_LATENCY = 2,
  parameter int SHADOW_IDX  = DEF_SHADOW_IDX
) (
  input  logic             iClk,
  input  logic             iReset_n,
  pe_bypass_ctrl_if.slave  bp
);

  ex_rec_t rec_q, rec_d;
  bp_out_t out_q, out_d;
  logic    m_a, m_b, hazard, issue;

  always_comb begin
    rec_d  = rec_q;
    out_d  = out_q;
    m_a    = bp.iIF_Read_En_A & rec_q.vld & (bp.iIF_RF_Read_Addr_A == rec_q.dst);
    m_b    = bp.iIF_Read_En_B & rec_q.vld & (bp.iIF_RF_Read_Addr_B == rec_q.dst);
    hazard = bp.iIF_Valid & (m_a | m_b) & rec_q.rem;
    issue  = bp.iIF_Valid & ~hazard & ~bp.iPipe_Stall;

    if (!bp.iPipe_Stall) begin
      // Bubbles and idle cycles retire the producer to WB, where the RF port bypass covers it.
      out_d     = '0;
      rec_d.vld = 1'b0;
      if (issue) begin
        out_d.rd_a  = m_a & ~rec_q.rem;
        out_d.rd_b  = m_b & ~rec_q.rem;
        out_d.sel_a = out_d.rd_a ? rec_q.src : BYPASS_SRC_ALU;
        out_d.sel_b = out_d.rd_b ? rec_q.src : BYPASS_SRC_ALU;
        // r0/r1 never forward.
        rec_d.vld   = bp.iIF_Dest_Write & (bp.iIF_Dest_Addr > RF_IDX_W'(1));
        rec_d.dst   = bp.iIF_Dest_Addr;
        rec_d.src   = (bp.iIF_Dest_Addr == RF_IDX_W'(SHADOW_IDX)) ? BYPASS_SRC_SHADOW
                                                                  : bypass_src_e'(bp.iIF_Dest_Src);
        rec_d.rem   = rem_init(bypass_src_e'(bp.iIF_Dest_Src), MUL_LATENCY, LSU_LATENCY);
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rec_q <= '0;
      out_q <= '0;
    end else begin
      rec_q <= rec_d;
      out_q <= out_d;
    end
  end

  assign bp.oBP_Bypass_Read_A = out_q.rd_a;
  assign bp.oBP_Bypass_Read_B = out_q.rd_b;
  assign bp.oBP_Bypass_Sel_A  = out_q.sel_a;
  assign bp.oBP_Bypass_Sel_B  = out_q.sel_b;
  assign bp.oHazard_Stall     = hazard;

endmodule

// File: tb/tb_pe_bypass_ctrl.sv
// Bench for pe_bypass_ctrl: directed vector table, corner sequences, random vs reference model.
module tb_pe_bypass_ctrl;

  localparam int MUL_LAT = 2;
  localparam int LSU_LAT = 2;

  typedef struct {
    logic       st, v;
    logic [4:0] ra, rb;
    logic       ea, eb, dw;
    logic [4:0] da;
    logic [1:0] ds;
    logic       haz, rda, rdb;
    logic [1:0] sela, selb;
  } vec_t;

  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pe_bypass_ctrl_if #(.RF_IDX_W(5)) bp_if ();

  pe_bypass_ctrl #(
    .RF_IDX_W(5), .MUL_LATENCY(MUL_LAT), .LSU_LATENCY(LSU_LAT), .SHADOW_IDX(31)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .bp(bp_if)
  );

  always #5 iClk = ~iClk;

  function automatic vec_t mk(input logic st, input logic v, input int ra, input int rb,
                              input logic ea, input logic eb, input logic dw, input int da,
                              input int ds, input logic haz, input logic rda, input logic rdb,
                              input int sela, input int selb);
    vec_t r;
    r.st = st; r.v = v; r.ra = 5'(ra); r.rb = 5'(rb);
    r.ea = ea; r.eb = eb; r.dw = dw; r.da = 5'(da); r.ds = 2'(ds);
    r.haz = haz; r.rda = rda; r.rdb = rdb; r.sela = 2'(sela); r.selb = 2'(selb);
    return r;
  endfunction

  task automatic drive(input vec_t x);
    bp_if.iPipe_Stall        = x.st;
    bp_if.iIF_Valid          = x.v;
    bp_if.iIF_RF_Read_Addr_A = x.ra;
    bp_if.iIF_RF_Read_Addr_B = x.rb;
    bp_if.iIF_Read_En_A      = x.ea;
    bp_if.iIF_Read_En_B      = x.eb;
    bp_if.iIF_Dest_Write     = x.dw;
    bp_if.iIF_Dest_Addr      = x.da;
    bp_if.iIF_Dest_Src       = x.ds;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return 8'({bp_if.oBP_Bypass_Read_A, bp_if.oBP_Bypass_Read_B,
               bp_if.oBP_Bypass_Sel_A, bp_if.oBP_Bypass_Sel_B});
  endfunction

  function automatic int lat_of(input int src);
    if (src == 1) return MUL_LAT;
    if (src == 2) return LSU_LAT;
    return 1;
  endfunction

  function automatic int rnd_addr();
    if ($urandom_range(0, 7) == 0) return 31;
    return int'($urandom_range(0, 7));
  endfunction

  vec_t tbl[24];

  // Reference model: the producer in EX is whatever issued in the last unfrozen cycle.
  bit   p_vld;
  int   p_dst, p_src, p_lat;
  logic e_rda, e_rdb;
  logic [1:0] e_sela, e_selb;

  initial begin
    vec_t x;
    logic e_haz, hit_a, hit_b, iss;

    tbl[0]  = mk(0,1, 0, 0, 0,0,1, 5,0, 0, 0,0,0,0);
    tbl[1]  = mk(0,1, 5, 5, 1,1,1, 6,0, 0, 1,1,0,0);
    tbl[2]  = mk(0,1, 0, 0, 0,0,1, 7,1, 0, 0,0,0,0);
    tbl[3]  = mk(0,1, 7, 0, 1,0,1, 8,0, 1, 0,0,0,0);
    tbl[4]  = mk(0,1, 7, 0, 1,0,1, 8,0, 0, 0,0,0,0);
    tbl[5]  = mk(0,1, 0, 0, 0,0,1, 1,0, 0, 0,0,0,0);
    tbl[6]  = mk(0,1, 1, 1, 1,1,1,31,0, 0, 0,0,0,0);
    tbl[7]  = mk(0,1,31,31, 1,1,1, 9,2, 0, 1,1,3,3);
    tbl[8]  = mk(0,1, 9, 9, 0,0,0, 0,0, 0, 0,0,0,0);
    tbl[9]  = mk(0,1, 0, 0, 0,0,1,10,2, 0, 0,0,0,0);
    tbl[10] = mk(0,1, 0,10, 0,1,0, 0,0, 1, 0,0,0,0);
    tbl[11] = mk(0,1, 0,10, 0,1,0, 0,0, 0, 0,0,0,0);
    tbl[12] = mk(0,1, 0, 0, 0,0,1,11,0, 0, 0,0,0,0);
    tbl[13] = mk(0,1,11, 0, 1,0,1,31,0, 0, 1,0,0,0);
    tbl[14] = mk(1,1,31, 0, 1,0,0, 0,0, 0, 1,0,0,0);
    tbl[15] = mk(1,1,31, 0, 1,0,0, 0,0, 0, 1,0,0,0);
    tbl[16] = mk(1,1,31, 0, 1,0,0, 0,0, 0, 1,0,0,0);
    tbl[17] = mk(0,1,31, 0, 1,0,0, 0,0, 0, 1,0,3,0);
    tbl[18] = mk(0,0,31, 0, 1,0,0, 0,0, 0, 0,0,0,0);
    tbl[19] = mk(0,1,31, 0, 1,0,0, 0,0, 0, 0,0,0,0);
    tbl[20] = mk(0,1, 0, 0, 0,0,1,20,1, 0, 0,0,0,0);
    tbl[21] = mk(1,1,20, 0, 1,0,0, 0,0, 1, 0,0,0,0);
    tbl[22] = mk(0,1,20, 0, 1,0,0, 0,0, 1, 0,0,0,0);
    tbl[23] = mk(0,1,20, 0, 1,0,0, 0,0, 0, 0,0,0,0);

    // Reset held with a valid, self-matching instruction present.
    drive(mk(0,1, 5, 5, 1,1,1, 5,1, 0, 0,0,0,0));
    repeat (3) @(posedge iClk);
    #1;
    chk("reset_outs", 0, outs(), 8'h00);
    chk("reset_haz", 0, 8'(bp_if.oHazard_Stall), 8'h00);
    @(negedge iClk);
    iReset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge iClk);
      drive(tbl[i]);
      #1;
      chk("tbl_haz", i, 8'(bp_if.oHazard_Stall), 8'(tbl[i].haz));
      @(posedge iClk);
      #1;
      chk("tbl_outs", i, outs(), 8'({tbl[i].rda, tbl[i].rdb, tbl[i].sela, tbl[i].selb}));
    end

    // Reset asserted while a MUL hazard is pending drops the stall at once.
    @(negedge iClk);
    drive(mk(0,1, 0, 0, 0,0,1, 7,1, 0, 0,0,0,0));
    @(negedge iClk);
    drive(mk(1,1, 7, 0, 1,0,0, 0,0, 0, 0,0,0,0));
    #1;
    chk("midrst_haz_pre", 0, 8'(bp_if.oHazard_Stall), 8'h01);
    iReset_n = 1'b0;
    #1;
    chk("midrst_haz_post", 0, 8'(bp_if.oHazard_Stall), 8'h00);
    chk("midrst_outs", 0, outs(), 8'h00);
    @(negedge iClk);
    iReset_n = 1'b1;

    p_vld = 0; p_dst = 0; p_src = 0; p_lat = 1;
    e_rda = 0; e_rdb = 0; e_sela = 0; e_selb = 0;

    for (int c = 0; c < 600; c++) begin
      @(negedge iClk);
      x = mk(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0), rnd_addr(), rnd_addr(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rnd_addr(), int'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      drive(x);
      hit_a = x.ea && p_vld && (int'(x.ra) == p_dst);
      hit_b = x.eb && p_vld && (int'(x.rb) == p_dst);
      e_haz = x.v && (hit_a || hit_b) && (p_lat > 1);
      #1;
      chk("rnd_haz", c, 8'(bp_if.oHazard_Stall), 8'(e_haz));
      @(posedge iClk);
      if (!x.st) begin
        iss    = x.v && !e_haz;
        e_rda  = iss && hit_a;
        e_rdb  = iss && hit_b;
        e_sela = e_rda ? 2'(p_src) : 2'd0;
        e_selb = e_rdb ? 2'(p_src) : 2'd0;
        if (iss && x.dw && x.da > 5'd1) begin
          p_vld = 1;
          p_dst = int'(x.da);
          p_src = (x.da == 5'd31) ? 3 : int'(x.ds);
          p_lat = lat_of(int'(x.ds));
        end else begin
          p_vld = 0;
        end
      end
      #1;
      chk("rnd_outs", c, outs(), 8'({e_rda, e_rdb, e_sela, e_selb}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
